// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared memory port.
//   slave  : arbiter side (takes IF/DM requests and mem_rdata, drives grants, dones, rdata, mem_*, busy)
//   master : requesters/memory side (drives requests and mem_rdata, observes the rest)
interface mem_port_arbiter_if #(parameter int N = 32);
  logic         if_req;
  logic [N-1:0] if_addr;
  logic         if_gnt;
  logic         if_done;
  logic [N-1:0] if_rdata;
  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic [2:0]   dm_access;
  logic         dm_gnt;
  logic         dm_done;
  logic [N-1:0] dm_rdata;
  logic         mem_en;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [2:0]   mem_access;
  logic [N-1:0] mem_rdata;
  logic         busy;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_access, mem_rdata,
    output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_access, busy
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_access, mem_rdata,
    input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_access, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and data access (DM).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (IF/DM request-grant-done, memory port, busy)
//   Each access: IDLE (arbitrate, latch port) -> ACCESS x LATENCY -> DONE (done pulse) -> IDLE.
//   ARB_ROUND_ROBIN_EN defined: ties go to the requester that did not own the last access;
//   undefined: DM wins every tie.
module mem_port_arbiter #(
  parameter int N       = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  state_t     state;
  owner_t     owner;
  logic [CNT_W-1:0] cnt;
  logic       pick_dm;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t     last_owner;
  assign pick_dm = bus.dm_req && (!bus.if_req || last_owner == OWN_IF);
`else
  assign pick_dm = bus.dm_req;
`endif
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= OWN_IF;
      cnt            <= '0;
      bus.if_gnt     <= 1'b0;
      bus.if_done    <= 1'b0;
      bus.if_rdata   <= '0;
      bus.dm_gnt     <= 1'b0;
      bus.dm_done    <= 1'b0;
      bus.dm_rdata   <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_access <= '0;
    end else begin
      bus.if_gnt  <= 1'b0;
      bus.dm_gnt  <= 1'b0;
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      bus.mem_we  <= 1'b0;
      case (state)
        IDLE: if (bus.if_req || bus.dm_req) begin
          state          <= ACCESS;
          owner          <= pick_dm ? OWN_DM : OWN_IF;
          cnt            <= CNT_W'(LATENCY - 1);
          bus.if_gnt     <= !pick_dm;
          bus.dm_gnt     <= pick_dm;
          bus.mem_en     <= 1'b1;
          // strobe lasts only the first ACCESS cycle; the default above clears it
          bus.mem_we     <= pick_dm && bus.dm_we;
          bus.mem_addr   <= pick_dm ? bus.dm_addr : bus.if_addr;
          bus.mem_wdata  <= pick_dm ? bus.dm_wdata : '0;
          // instruction fetches are always full words
          bus.mem_access <= pick_dm ? bus.dm_access : 3'b010;
        end
        ACCESS: if (cnt == '0) begin
          state       <= DONE;
          bus.mem_en  <= 1'b0;
          bus.if_done <= owner == OWN_IF;
          bus.dm_done <= owner == OWN_DM;
          // stores also load dm_rdata; the value is meaningless but harmless
          if (owner == OWN_DM) bus.dm_rdata <= bus.mem_rdata;
          else bus.if_rdata <= bus.mem_rdata;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner <= OWN_IF;
    else if (state == IDLE && (bus.if_req || bus.dm_req)) last_owner <= pick_dm ? OWN_DM : OWN_IF;
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a done/write scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.N(32)) b ();
  mem_port_arbiter_if #(.N(32)) b1 ();
  mem_port_arbiter #(.N(32), .LATENCY(2), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  mem_port_arbiter #(.N(32), .LATENCY(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  typedef struct {bit dm; logic [31:0] rdata; int cyc;} exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [2:0] access;} wexp_t;
  exp_t  q[$];
  exp_t  q1[$];
  wexp_t wq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a == 32'h100 ? 32'h0010_0093 : a ^ 32'h5A5A_0000;
  endfunction
  always_comb b.mem_rdata = rd_model(b.mem_addr);
  always_comb b1.mem_rdata = rd_model(b1.mem_addr);
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    wexp_t w;
    if (b.if_done || b.dm_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=if%b/dm%b required=none (cycle %0d)", b.if_done, b.dm_done, cyc);
      end else begin
        e = q.pop_front();
        chk("done_owner", {30'b0, b.dm_done, b.if_done}, e.dm ? 32'd2 : 32'd1);
        chk("done_rdata", e.dm ? b.dm_rdata : b.if_rdata, e.rdata);
        chk("done_cycle", cyc, e.cyc);
      end
    end
    if (b.mem_we) begin
      we_cnt++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we actual=%h required=none", b.mem_addr);
      end else begin
        w = wq.pop_front();
        chk("we_addr", b.mem_addr, w.addr);
        chk("we_wdata", b.mem_wdata, w.wdata);
        chk("we_access", {29'b0, b.mem_access}, {29'b0, w.access});
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (b1.if_done || b1.dm_done) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_l1 actual=if%b/dm%b required=none (cycle %0d)", b1.if_done, b1.dm_done, cyc);
      end else begin
        e = q1.pop_front();
        chk("l1_done_owner", {31'b0, b1.if_done}, 32'd1);
        chk("l1_done_rdata", b1.if_rdata, e.rdata);
        chk("l1_done_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic wait_done(input bit dm, input int budget);
    int n = 0;
    while (!(dm ? b.dm_done : b.if_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(dm ? b.dm_done : b.if_done)) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=none required=done within %0d cycles", dm ? "dm" : "if", budget);
    end
    if (dm) b.dm_req = 1'b0;
    else b.if_req = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_we = 0; b.dm_addr = 0; b.dm_wdata = 0; b.dm_access = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0; b1.dm_access = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", b.busy, 0);
    chk("rst_mem_en", b.mem_en, 0);
    chk("rst_mem_addr", b.mem_addr, 0);
    chk("rst_if_rdata", b.if_rdata, 0);
    chk("rst_dm_rdata", b.dm_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    c0 = cyc;
    b.if_addr = 32'h100;
    b.if_req = 1'b1;
    q.push_back('{dm: 1'b0, rdata: 32'h0010_0093, cyc: c0 + 3});
    @(negedge clk);
    chk("t1_if_gnt_c1", b.if_gnt, 1);
    chk("t1_mem_addr_c1", b.mem_addr, 32'h100);
    chk("t1_mem_en_c1", b.mem_en, 1);
    chk("t1_busy_c1", b.busy, 1);
    @(negedge clk);
    chk("t1_if_gnt_c2", b.if_gnt, 0);
    chk("t1_mem_addr_c2", b.mem_addr, 32'h100);
    chk("t1_mem_en_c2", b.mem_en, 1);
    wait_done(1'b0, 10);
    chk("t1_done_mem_en", b.mem_en, 0);
    @(negedge clk);
    chk("t1_idle_busy", b.busy, 0);
    c0 = cyc;
    b.dm_addr = 32'h2000;
    b.dm_wdata = 32'hDEAD_BEEF;
    b.dm_access = 3'b010;
    b.dm_we = 1'b1;
    b.dm_req = 1'b1;
    wq.push_back('{addr: 32'h2000, wdata: 32'hDEAD_BEEF, access: 3'b010});
    q.push_back('{dm: 1'b1, rdata: 32'h5A5A_2000, cyc: c0 + 3});
    wait_done(1'b1, 10);
    chk("t2_we_count", we_cnt, 1);
    b.dm_we = 1'b0;
    @(negedge clk);
    c0 = cyc;
    b.dm_addr = 32'h3000;
    b.if_addr = 32'h104;
    b.dm_req = 1'b1;
    b.if_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    q.push_back('{dm: 1'b0, rdata: 32'h5A5A_0104, cyc: c0 + 3});
    q.push_back('{dm: 1'b1, rdata: 32'h5A5A_3000, cyc: c0 + 7});
`else
    q.push_back('{dm: 1'b1, rdata: 32'h5A5A_3000, cyc: c0 + 3});
    q.push_back('{dm: 1'b0, rdata: 32'h5A5A_0104, cyc: c0 + 7});
`endif
    fork
      wait_done(1'b1, 20);
      wait_done(1'b0, 20);
    join
    @(negedge clk);
    b.dm_addr = 32'h4000;
    b.dm_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", b.busy, 0);
    chk("t5_rst_mem_en", b.mem_en, 0);
    chk("t5_rst_mem_addr", b.mem_addr, 0);
    chk("t5_rst_dm_rdata", b.dm_rdata, 0);
    chk("t5_rst_if_rdata", b.if_rdata, 0);
    b.dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_after_busy", b.busy, 0);
    c0 = cyc;
    b.if_addr = 32'h108;
    b.if_req = 1'b1;
    q.push_back('{dm: 1'b0, rdata: 32'h5A5A_0108, cyc: c0 + 3});
    wait_done(1'b0, 10);
    @(negedge clk);
    c0 = cyc;
    b1.if_addr = 32'h200;
    b1.if_req = 1'b1;
    for (int k = 2; k <= 8; k += 3) q1.push_back('{dm: 1'b0, rdata: 32'h5A5A_0200, cyc: c0 + k});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t6_mem_en", b1.mem_en, k % 3 == 1);
      if (k == 8) b1.if_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("q_empty", q.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("we_total", we_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
